vslc_scan_ctrl: RTL and testbench

Parametrised scan-cycle controller for the VSLC core. It parses the 4-byte program header from the EEPROM reader's byte stream and issues reader restarts at the program end address. It generates scan-cycle pulses from auto-restart or an external trigger, and snapshots the inputs with edge vectors. It also produces a clock-enable strobe for the SPI clock, replacing the previous derived-clock scheme, and sits between the EEPROM reader and the executor.

---
 rtl/vslc_scan_ctrl_if.sv | 39 +++
 rtl/vslc_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_vslc_scan_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vslc_scan_ctrl_if.sv
// Signal bundle between the EEPROM reader, the VSLC scan controller and the executor.
// master drives reader bytes, trigger, raw inputs and divider select; slave is the controller.
interface vslc_scan_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned IN_W   = 8,
  parameter int unsigned DIV_W  = 4
);
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [DIV_W-1:0]  div_sel;
  logic              trig_in;
  logic [IN_W-1:0]   in_raw;

  logic              sck_en;
  logic              restart;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              instr_valid;
  logic              scan_pulse;
  logic [IN_W-1:0]   in_cur;
  logic [IN_W-1:0]   in_prev;
  logic [IN_W-1:0]   in_rise;
  logic [IN_W-1:0]   in_fall;
  logic [15:0]       scan_count;
  logic              wdog_trip;

  modport master (
    output rd_valid, rd_addr, rd_data, div_sel, trig_in, in_raw,
    input  sck_en, restart, start_addr, end_addr, instr_valid, scan_pulse,
           in_cur, in_prev, in_rise, in_fall, scan_count, wdog_trip
  );

  modport slave (
    input  rd_valid, rd_addr, rd_data, div_sel, trig_in, in_raw,
    output sck_en, restart, start_addr, end_addr, instr_valid, scan_pulse,
           in_cur, in_prev, in_rise, in_fall, scan_count, wdog_trip
  );
endinterface

// File: rtl/vslc_scan_ctrl.sv
// VSLC scan-cycle controller: program header parse, reader restart, scan pulses, input snapshots, SPI strobe.
// Optional watchdog restart enabled by defining VSLC_SCAN_WATCHDOG_EN.
module vslc_scan_ctrl #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned IN_W        = 8,
  parameter int unsigned DIV_W       = 4,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input logic             clk,
  input logic             rst,
  vslc_scan_ctrl_if.slave bus
);
  localparam int unsigned PRE_W = 1 << DIV_W;

  if (ADDR_W < 10 || ADDR_W > 16 || WDOG_CYCLES == 0) begin : g_bad_param
    $error("vslc_scan_ctrl: ADDR_W must be 10..16 and WDOG_CYCLES nonzero");
  end

  typedef enum logic [1:0] {HDR, RUN, RESTART} state_t;

  state_t            state, state_nxt;
  logic              restart, restart_nxt;
  logic              scan_pulse;
  logic [ADDR_W-1:0] start_addr, end_addr;
  logic [ADDR_W-1:0] hdr_hi;
  logic              end_hit;
  logic              wdog_hit;
  logic              wdog_trip;
  logic [2:0]        trig_sync;
  logic              trig_rise;
  logic [IN_W-1:0]   in_s1, in_s2, in_cur, in_prev;
  logic [15:0]       scan_count;
  logic [PRE_W-1:0]  presc;

  // High header byte aligned to bit 8; bits beyond ADDR_W fall off the cast.
  assign hdr_hi  = ADDR_W'({bus.rd_data, 8'h00});
  assign end_hit = bus.rd_valid && (end_addr != '0) && (bus.rd_addr >= end_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HDR;
      restart <= 1'b0;
    end else begin
      state   <= state_nxt;
      restart <= restart_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    restart_nxt = 1'b0;
    case (state)
      HDR: begin
        if (bus.rd_valid && bus.rd_addr == ADDR_W'(3)) state_nxt = RUN;
      end
      RUN: begin
        if (end_hit) begin
          restart_nxt = 1'b1;
          state_nxt   = RESTART;
        end
      end
      RESTART: begin
        // The start byte is already program input, so it is end-checked too.
        if (bus.rd_valid && bus.rd_addr == start_addr) begin
          if (end_hit) restart_nxt = 1'b1;
          else         state_nxt   = RUN;
        end
      end
      default: state_nxt = HDR;
    endcase
    if (wdog_hit) begin
      restart_nxt = 1'b1;
      state_nxt   = RESTART;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_addr <= '0;
      end_addr   <= '0;
    end else if (state == HDR && bus.rd_valid) begin
      case (bus.rd_addr)
        ADDR_W'(0): start_addr[ADDR_W-1:8] <= hdr_hi[ADDR_W-1:8];
        ADDR_W'(1): start_addr[7:0]        <= bus.rd_data;
        ADDR_W'(2): end_addr[ADDR_W-1:8]   <= hdr_hi[ADDR_W-1:8];
        ADDR_W'(3): end_addr[7:0]          <= bus.rd_data;
        default: ;
      endcase
    end
  end

`ifdef VSLC_SCAN_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_cnt;

  assign wdog_hit = !bus.rd_valid && (state != HDR) && (wdog_cnt == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
    end else begin
      if (bus.rd_valid || state == HDR || wdog_hit) wdog_cnt <= '0;
      else                                          wdog_cnt <= wdog_cnt + WD_W'(1);
      if (wdog_hit) wdog_trip <= 1'b1;
    end
  end
`else
  assign wdog_hit  = 1'b0;
  assign wdog_trip = 1'b0;
`endif

  assign trig_rise = trig_sync[1] & ~trig_sync[2];

  // Synchronizers, scan pulse and snapshot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_sync  <= '0;
      in_s1      <= '0;
      in_s2      <= '0;
      scan_pulse <= 1'b0;
      in_cur     <= '0;
      in_prev    <= '0;
      scan_count <= '0;
    end else begin
      trig_sync  <= {trig_sync[1:0], bus.trig_in};
      in_s1      <= bus.in_raw;
      in_s2      <= in_s1;
      scan_pulse <= restart | trig_rise;
      if (scan_pulse) begin
        in_prev    <= in_cur;
        in_cur     <= in_s2;
        scan_count <= scan_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc <= '0;
    else     presc <= presc + PRE_W'(1);
  end

  // Strobe when the low div_sel prescaler bits are all ones; the shifted mask fills the rest.
  assign bus.sck_en      = &(presc | ({PRE_W{1'b1}} << bus.div_sel));
  assign bus.restart     = restart;
  assign bus.start_addr  = start_addr;
  assign bus.end_addr    = end_addr;
  assign bus.instr_valid = bus.rd_valid && (state != HDR) && (bus.rd_addr >= ADDR_W'(4));
  assign bus.scan_pulse  = scan_pulse;
  assign bus.in_cur      = in_cur;
  assign bus.in_prev     = in_prev;
  assign bus.in_rise     = in_cur & ~in_prev;
  assign bus.in_fall     = ~in_cur & in_prev;
  assign bus.scan_count  = scan_count;
  assign bus.wdog_trip   = wdog_trip;
endmodule

// File: tb/tb_vslc_scan_ctrl.sv
// Directed bench for vslc_scan_ctrl: vector tables for header/restart flow, hand sequences for triggers,
// coincident restart+trigger, SPI strobe, reset mid-RESTART and (when VSLC_SCAN_WATCHDOG_EN) the watchdog.
module tb_vslc_scan_ctrl;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned IN_W   = 8;
  localparam int unsigned DIV_W  = 4;
  localparam int unsigned WDOG   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vslc_scan_ctrl_if #(.ADDR_W(ADDR_W), .IN_W(IN_W), .DIV_W(DIV_W)) bus ();

  vslc_scan_ctrl #(.ADDR_W(ADDR_W), .IN_W(IN_W), .DIV_W(DIV_W), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic              rv;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              iv;
    logic              rs;
    logic              sp;
    logic [ADDR_W-1:0] sa;
    logic [ADDR_W-1:0] ea;
    logic [15:0]       cnt;
  } vec_t;

  vec_t vq[$];
  int   errors  = 0;
  int   checks  = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rv, input int addr, input int data, input logic iv, input logic rs,
                     input logic sp, input int sa, input int ea, input int cnt);
    vq.push_back('{rv, ADDR_W'(addr), 8'(data), iv, rs, sp, ADDR_W'(sa), ADDR_W'(ea), 16'(cnt)});
  endtask

  // One vector per cycle: driven just after a falling edge, registered results checked at the next one.
  task automatic run_vectors(input string tag);
    foreach (vq[i]) begin
      bus.rd_valid = vq[i].rv;
      bus.rd_addr  = vq[i].addr;
      bus.rd_data  = vq[i].data;
      #1 chk($sformatf("%s[%0d].instr_valid", tag, i), 32'(bus.instr_valid), 32'(vq[i].iv));
      @(negedge clk);
      chk($sformatf("%s[%0d].restart", tag, i),    32'(bus.restart),    32'(vq[i].rs));
      chk($sformatf("%s[%0d].scan_pulse", tag, i), 32'(bus.scan_pulse), 32'(vq[i].sp));
      chk($sformatf("%s[%0d].start_addr", tag, i), 32'(bus.start_addr), 32'(vq[i].sa));
      chk($sformatf("%s[%0d].end_addr", tag, i),   32'(bus.end_addr),   32'(vq[i].ea));
      chk($sformatf("%s[%0d].scan_count", tag, i), 32'(bus.scan_count), 32'(vq[i].cnt));
    end
    vq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".restart"},     32'(bus.restart),     0);
    chk({tag, ".scan_pulse"},  32'(bus.scan_pulse),  0);
    chk({tag, ".start_addr"},  32'(bus.start_addr),  0);
    chk({tag, ".end_addr"},    32'(bus.end_addr),    0);
    chk({tag, ".instr_valid"}, 32'(bus.instr_valid), 0);
    chk({tag, ".in_cur"},      32'(bus.in_cur),      0);
    chk({tag, ".in_prev"},     32'(bus.in_prev),     0);
    chk({tag, ".in_rise"},     32'(bus.in_rise),     0);
    chk({tag, ".in_fall"},     32'(bus.in_fall),     0);
    chk({tag, ".scan_count"},  32'(bus.scan_count),  0);
    chk({tag, ".wdog_trip"},   32'(bus.wdog_trip),   0);
    chk({tag, ".sck_en"},      32'(bus.sck_en),      32'(bus.div_sel == '0));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs(tag);
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    exp_cnt = 0;
  endtask

  // Trigger rise lands on scan_pulse exactly three cycles later.
  task automatic trig_scan(input string tag);
    repeat (3) @(negedge clk);
    bus.trig_in = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk({tag, ".early_pulse"}, 32'(bus.scan_pulse), 0);
    end
    @(negedge clk);
    chk({tag, ".scan_pulse"}, 32'(bus.scan_pulse), 1);
    bus.trig_in = 1'b0;
    exp_cnt++;
    @(negedge clk);
    chk({tag, ".pulse_width"}, 32'(bus.scan_pulse), 0);
    chk({tag, ".scan_count"},  32'(bus.scan_count), 32'(exp_cnt));
  endtask

  task automatic sck_test(input int sel, input int exp_hi);
    int hi   = 0;
    int last = -1;
    int gap  = 0;
    bus.div_sel = DIV_W'(sel);
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.sck_en) begin
        if (last >= 0) gap = i - last;
        last = i;
        hi++;
      end
    end
    chk($sformatf("sck_en.count.sel%0d", sel),  32'(hi),  32'(exp_hi));
    chk($sformatf("sck_en.period.sel%0d", sel), 32'(gap), 32'(64 / exp_hi));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    int k;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = ADDR_W'(32);
    bus.rd_data  = 8'h00;
    bus.div_sel  = '0;
    bus.trig_in  = 1'b0;
    bus.in_raw   = '0;

    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Header 00 10 00 40, end-address restart, RESTART ignores bytes until start_addr.
    add(1, 'h000, 'h00, 0, 0, 0, 'h000, 'h000, 0);
    add(1, 'h001, 'h10, 0, 0, 0, 'h010, 'h000, 0);
    add(1, 'h002, 'h00, 0, 0, 0, 'h010, 'h000, 0);
    add(1, 'h003, 'h40, 0, 0, 0, 'h010, 'h040, 0);
    add(1, 'h004, 'hAA, 1, 0, 0, 'h010, 'h040, 0);
    add(1, 'h040, 'h00, 1, 1, 0, 'h010, 'h040, 0);
    add(1, 'h020, 'h00, 1, 0, 1, 'h010, 'h040, 0);
    add(1, 'h041, 'h00, 1, 0, 0, 'h010, 'h040, 1);
    add(1, 'h3FF, 'h00, 1, 0, 0, 'h010, 'h040, 1);
    add(1, 'h010, 'h00, 1, 0, 0, 'h010, 'h040, 1);
    add(1, 'h03F, 'h00, 1, 0, 0, 'h010, 'h040, 1);
    add(1, 'h001, 'hFF, 0, 0, 0, 'h010, 'h040, 1);
    add(1, 'h020, 'h00, 1, 0, 0, 'h010, 'h040, 1);
    run_vectors("hdr1");
    exp_cnt = 1;

    // Input snapshots and edge vectors across two triggered scans.
    bus.rd_addr = ADDR_W'('h020);
    bus.in_raw  = 8'hA5;
    trig_scan("trig1");
    chk("trig1.in_cur",  32'(bus.in_cur),  32'h0A5);
    chk("trig1.in_prev", 32'(bus.in_prev), 32'h000);
    bus.in_raw = 8'h3C;
    trig_scan("trig2");
    chk("trig2.in_prev", 32'(bus.in_prev), 32'h0A5);
    chk("trig2.in_cur",  32'(bus.in_cur),  32'h03C);
    chk("trig2.in_rise", 32'(bus.in_rise), 32'h018);
    chk("trig2.in_fall", 32'(bus.in_fall), 32'h081);

    // Trigger edge and end-address restart reach the pulse register together: one scan.
    repeat (3) @(negedge clk);
    bus.trig_in = 1'b1;
    @(negedge clk);
    bus.rd_addr = ADDR_W'('h040);
    @(negedge clk);
    chk("coincide.restart", 32'(bus.restart), 1);
    bus.rd_addr = ADDR_W'('h020);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.scan_pulse) pulses++;
    end
    exp_cnt++;
    chk("coincide.pulses",     32'(pulses),         1);
    chk("coincide.scan_count", 32'(bus.scan_count), 32'(exp_cnt));
    bus.trig_in = 1'b0;
    bus.rd_addr = ADDR_W'('h010);
    @(negedge clk);
    bus.rd_addr = ADDR_W'('h020);

    sck_test(3, 8);
    sck_test(0, 64);
    sck_test(1, 32);

    // Enter RESTART, then reset while there.
    bus.rd_addr = ADDR_W'('h040);
    @(negedge clk);
    chk("midrst.restart", 32'(bus.restart), 1);
    bus.rd_addr = ADDR_W'('h020);
    bus.div_sel = DIV_W'(2);
    do_reset("midrst");
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("postrst[%0d].instr_valid", i), 32'(bus.instr_valid), 0);
      @(negedge clk);
      chk($sformatf("postrst[%0d].restart", i),    32'(bus.restart),    0);
      chk($sformatf("postrst[%0d].scan_pulse", i), 32'(bus.scan_pulse), 0);
    end
    bus.div_sel = '0;

    // Header high bytes wider than ADDR_W are truncated; start byte is end-checked in RESTART.
    add(1, 'h000, 'hFD, 0, 0, 0, 'h100, 'h000, 0);
    add(1, 'h001, 'h10, 0, 0, 0, 'h110, 'h000, 0);
    add(1, 'h002, 'h03, 0, 0, 0, 'h110, 'h300, 0);
    add(1, 'h003, 'hFF, 0, 0, 0, 'h110, 'h3FF, 0);
    add(1, 'h3FF, 'h00, 1, 1, 0, 'h110, 'h3FF, 0);
    add(1, 'h110, 'h00, 1, 0, 1, 'h110, 'h3FF, 0);
    add(1, 'h020, 'h00, 1, 0, 0, 'h110, 'h3FF, 1);
    run_vectors("hdr2");

    // end_addr == 0 disables auto restart.
    do_reset("rst3");
    add(1, 'h000, 'h00, 0, 0, 0, 'h000, 'h000, 0);
    add(1, 'h001, 'h10, 0, 0, 0, 'h010, 'h000, 0);
    add(1, 'h002, 'h00, 0, 0, 0, 'h010, 'h000, 0);
    add(1, 'h003, 'h00, 0, 0, 0, 'h010, 'h000, 0);
    add(1, 'h3FF, 'h00, 1, 0, 0, 'h010, 'h000, 0);
    add(1, 'h020, 'h00, 1, 0, 0, 'h010, 'h000, 0);
    run_vectors("hdr3");

`ifdef VSLC_SCAN_WATCHDOG_EN
    // Reader stalls in RUN: watchdog restart after WDOG idle cycles, sticky trip flag.
    bus.rd_valid = 1'b0;
    k = 0;
    while (!bus.restart && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("wdog.latency",   32'(k),             32'(WDOG));
    chk("wdog.trip",      32'(bus.wdog_trip), 1);
    bus.rd_valid = 1'b1;
    bus.rd_addr  = ADDR_W'('h020);
    @(negedge clk);
    chk("wdog.scan_pulse", 32'(bus.scan_pulse), 1);
    exp_cnt++;
    trig_scan("wdog_trig");
    chk("wdog.trip_held", 32'(bus.wdog_trip), 1);
`else
    k = 0;
    bus.rd_valid = 1'b0;
    repeat (24) begin
      @(negedge clk);
      if (bus.restart) k++;
    end
    chk("nowdog.restarts", 32'(k),             0);
    chk("nowdog.trip",     32'(bus.wdog_trip), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
